// File: rtl/sm_fetch_queue.sv
// Instruction prefetch queue: fetches sequential words ahead of the CPU into a small FIFO
// and flushes/re-targets whenever the CPU address leaves the prefetched stream.
//   state | meaning
//   IDLE  | no request outstanding (queue full or waiting for a new target)
//   REQ   | request outstanding; returned word is pushed into the queue
//   DROP  | stale request outstanding after a redirect; returned word is discarded
module sm_fetch_queue #(
  parameter int unsigned DEPTH      = 4,
  parameter logic [31:0] RESET_ADDR = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] cpuAddr,
  input  logic        cpuTake,
  output logic [31:0] cpuData,
  output logic        cpuValid,
  output logic        cpuStall,
  output logic        memReq,
  output logic [31:0] memAddr,
  input  logic        memAck,
  input  logic [31:0] memData
);

  localparam int unsigned  AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned  CW   = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [31:0]   r_fifo_addr [DEPTH];
  logic [31:0]   r_fifo_data [DEPTH];
  logic [AW-1:0] r_rd_ptr, r_wr_ptr;
  logic [CW-1:0] r_count, w_count_after;
  logic [31:0]   r_fetch_addr, w_fetch_addr_nxt;
  logic [31:0]   r_mem_addr, w_mem_addr_nxt;

  logic w_empty, w_hit, w_keep_req, w_keep_idle, w_redirect, w_push, w_pop;

  assign w_empty  = (r_count == '0);
  assign w_hit    = !w_empty && (r_fifo_addr[r_rd_ptr] == cpuAddr);

  assign cpuValid = w_hit;
  assign cpuStall = ~w_hit;
  assign cpuData  = r_fifo_data[r_rd_ptr];
  assign memReq   = (r_state == S_REQ) || (r_state == S_DROP);
  assign memAddr  = r_mem_addr;

  // An empty queue is not a miss if the word the CPU wants is already being fetched
  // or is about to be fetched next.
  assign w_keep_req  = w_empty && (r_state == S_REQ)  && (r_mem_addr == cpuAddr);
  assign w_keep_idle = w_empty && (r_state == S_IDLE) && (r_fetch_addr == cpuAddr);
  assign w_redirect  = !w_hit && !w_keep_req && !w_keep_idle;

  assign w_pop  = w_hit && cpuTake;
  assign w_push = (r_state == S_REQ) && memAck && !w_redirect;

  assign w_count_after = r_count + CW'(w_push) - CW'(w_pop);

  always_comb begin
    w_state_nxt      = r_state;
    w_fetch_addr_nxt = r_fetch_addr;
    w_mem_addr_nxt   = r_mem_addr;
    case (r_state)
      S_IDLE: begin
        if (w_redirect) begin
          w_fetch_addr_nxt = cpuAddr;
        end else if (r_count < FULL) begin
          w_state_nxt    = S_REQ;
          w_mem_addr_nxt = r_fetch_addr;
        end
      end
      S_REQ: begin
        if (w_redirect) begin
          w_fetch_addr_nxt = cpuAddr;
          w_state_nxt      = memAck ? S_IDLE : S_DROP;
        end else if (memAck) begin
          w_fetch_addr_nxt = r_mem_addr + 32'd1;
          if (w_count_after < FULL) begin
            w_mem_addr_nxt = r_mem_addr + 32'd1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_DROP: begin
        // The stale request must still complete; it is never withdrawn.
        if (w_redirect) begin
          w_fetch_addr_nxt = cpuAddr;
        end
        if (memAck) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_fetch_addr <= RESET_ADDR;
      r_mem_addr   <= 32'h0;
    end else begin
      r_state      <= w_state_nxt;
      r_fetch_addr <= w_fetch_addr_nxt;
      r_mem_addr   <= w_mem_addr_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (w_redirect) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      r_count <= w_count_after;
    end
  end

  // Storage is cleared on reset so cpuData reads as zero while the queue is held in reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_fifo_addr[i] <= 32'h0;
        r_fifo_data[i] <= 32'h0;
      end
    end else if (w_push) begin
      r_fifo_addr[r_wr_ptr] <= r_mem_addr;
      r_fifo_data[r_wr_ptr] <= memData;
    end
  end

endmodule

// File: doc/sm_fetch_queue.md
SM_FETCH_QUEUE -- requirements
Module: sm_fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the number of prefetch entries (power of two, 2..16).
REQ-002 Parameter RESET_ADDR, default 32'h0, SHALL set the first word address fetched after reset.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the reset: asynchronous, active-high.
REQ-005 cpuAddr  input  32  SHALL be the CPU's current word address (instruction memory address).
REQ-006 cpuTake  input  1  SHALL indicate that the CPU consumes cpuData this cycle.
REQ-007 cpuData  output  32  SHALL be the instruction word for cpuAddr, meaningful only while cpuValid=1.
REQ-008 cpuValid  output  1  SHALL indicate that cpuData holds the word at cpuAddr.
REQ-009 cpuStall  output  1  SHALL equal ~cpuValid.
REQ-010 memReq  output  1  SHALL request a memory read.
REQ-011 memAddr  output  32  SHALL carry the word address of the outstanding request.
REQ-012 memAck  input  1  SHALL indicate completion of the current request.
REQ-013 memData  input  32  SHALL carry the read data, sampled only in cycles with memReq=1 and memAck=1.

Function
REQ-014 The block SHALL hold a FIFO of DEPTH entries {addr[31:0], data[31:0]}, plus an entry count, a fetch address register fetchAddr, and a state register with states IDLE, REQ, DROP.
REQ-015 memReq SHALL be 1 exactly in states REQ and DROP; memAddr SHALL be registered and stable while memReq=1 and memAck=0.
REQ-016 hit = (count != 0) & (head.addr == cpuAddr); cpuValid SHALL equal hit combinationally and cpuData SHALL equal head.data.
REQ-017 Pop SHALL occur on cycles where cpuValid=1 and cpuTake=1.
REQ-018 redirect SHALL be asserted when cpuValid=0, except in two cases: count=0, state=REQ, and memAddr==cpuAddr; or count=0, state=IDLE, and fetchAddr==cpuAddr.
REQ-019 On redirect, the FIFO SHALL be flushed (count=0) and fetchAddr SHALL load cpuAddr; state REQ SHALL go to DROP (or to IDLE if memAck=1 that same cycle); DROP SHALL stay DROP; IDLE SHALL stay IDLE.
REQ-020 In DROP, memReq SHALL stay high until memAck; the returned data SHALL be discarded and the state SHALL go to IDLE; an outstanding request is never withdrawn.
REQ-021 From IDLE without redirect, if count < DEPTH, the state SHALL go to REQ with memAddr=fetchAddr.
REQ-022 In REQ on memAck without redirect, the block SHALL push {memAddr, memData} and set fetchAddr=memAddr+1 (32-bit wrap from 32'hFFFFFFFF to 0).
  - If count after push-and-pop < DEPTH, the state SHALL remain REQ with memAddr=memAddr+1 (back-to-back issue).
  - Otherwise the state SHALL go to IDLE.
REQ-023 Simultaneous push and pop SHALL leave count unchanged; push SHALL never occur when full; pop SHALL never occur when empty.
REQ-024 Data SHALL be presented in fetch order; a word fetched before a redirect SHALL never be presented after it.
REQ-025 Latency: with a zero-wait memory (memAck=1 in the first REQ cycle), a word requested at cycle N SHALL be visible on cpuValid at cycle N+1; sustained throughput SHALL be one word per cycle.

Reset
REQ-026 While rst=1, outputs SHALL be: memReq=0, memAddr=0, cpuValid=0, cpuStall=1, cpuData=0.
REQ-027 While rst=1, internal state SHALL be: count=0, state=IDLE, fetchAddr=RESET_ADDR.
REQ-028 Reset asserted mid-request SHALL abandon the request immediately; the first cycle after release SHALL be IDLE.

Verification
REQ-029 Sequential run (zero-wait memory, memData=addr^32'hA5A50000, cpuTake=1, cpuAddr incremented on each take):
  - Release reset: memReq=1, memAddr=0 at cycle 1; cpuValid=1 with cpuData=32'hA5A50000 at cycle 2.
  - Then one word per cycle, no stalls.
REQ-030 Memory acks on the 3rd cycle of each request -> memAddr stable for 3 cycles, cpuValid pulses once per 3 cycles, addresses 0,1,2,... in order.
REQ-031 FIFO holds addresses 4,5,6 and cpuAddr jumps to 32'h20 -> cpuValid=0 that cycle, FIFO flushed, next request memAddr=32'h20, words 5 and 6 never presented.
REQ-032 Request for address 7 outstanding, cpuAddr jumps to 32'h40, ack 2 cycles later -> memReq held until ack (DROP), data discarded, next request memAddr=32'h40, cpuValid first matches 32'h40.
REQ-033 cpuTake=0 for 10 cycles -> count saturates at DEPTH=4, memReq=0, no overwrite; cpuTake=1 resumes -> words 0,1,2,3,4... presented in order.
REQ-034 rst pulsed while memReq=1 at memAddr=32'h9 -> memReq=0 and cpuValid=0 immediately; after release, memAddr=0 with no stale word presented.
